// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Bytes arrive on a one-cycle strobe and are queued. Each byte is sent as an
// 8N1 frame, LSB first. Queued bytes are sent back to back with no idle gap.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_fresh,
    output logic       tx_full,
    output logic       tx_overflow,
    output logic       tx_busy,
    output logic       tx
);

    localparam int unsigned Depth = 2 ** FIFO_AW;
    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0]  BaudMax   = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]  CountFull = (FIFO_AW + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               full_q, overflow_q, overflow_d;
    logic [7:0]         mem [Depth];
    logic               wr_en, pop, baud_end, fifo_nonempty;

    // The registered full flag gates writes, so a write seen while full is
    // dropped even when a pop frees a slot in the same cycle.
    assign wr_en         = tx_data_fresh & ~full_q;
    assign fifo_nonempty = (count_q != '0);
    assign baud_end      = (baud_q == BaudMax);

    // FIFO pointer, count and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (tx_data_fresh & full_q);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; it needs no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    // Serialiser next-state: one baud counter shared by all bit periods
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level follows the upcoming state so that tx is a clean register output
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State registers; reset aborts any frame and empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CountFull);
            overflow_q <= overflow_d;
        end
    end

    assign tx          = tx_q;
    assign tx_full     = full_q;
    assign tx_overflow = overflow_q;
    assign tx_busy     = (state_q != StIdle) | fifo_nonempty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with CLKS_PER_BIT=4 and a 4-entry FIFO.
// The reference model keeps a list of accepted bytes, with a write time and a
// frame start time for each. The expected line level, busy, full and
// overflow values for every cycle are computed from that list.
module tb_uart_tx_fifo;

    localparam int Cpb   = 4;
    localparam int Depth = 4;
    localparam int Frame = 10 * Cpb;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_data_fresh;
    logic       tx_full, tx_overflow, tx_busy, tx;

    uart_tx_fifo #(.CLKS_PER_BIT(Cpb), .FIFO_AW(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_data_fresh(tx_data_fresh),
        .tx_full      (tx_full),
        .tx_overflow  (tx_overflow),
        .tx_busy      (tx_busy),
        .tx           (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         t;   // cycle the write was accepted
        int         s;   // first cycle of its start bit
        logic [7:0] d;
    } ent_t;

    ent_t       m[$];
    logic [7:0] exp_bytes[$];
    logic [8:0] rx_q[$];
    int         cyc;
    int         total;
    int         bad;
    bit         ov_set;
    int         ov_at;
    int         last_end;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // FIFO occupancy seen during cycle c: bytes written before c minus bytes
    // popped before c (a byte is popped the cycle before its start bit).
    function automatic int count_at(input int c);
        int n = 0;
        foreach (m[i]) begin
            if (m[i].t < c) n++;
            if (m[i].s <= c) n--;
        end
        return n;
    endfunction

    function automatic logic tx_at(input int c);
        int k;
        foreach (m[i]) begin
            if (c >= m[i].s && c < m[i].s + Frame) begin
                k = (c - m[i].s) / Cpb;
                if (k == 0) return 1'b0;
                if (k == 9) return 1'b1;
                return m[i].d[k-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic in_frame(input int c);
        foreach (m[i]) begin
            if (c >= m[i].s && c < m[i].s + Frame) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_write(input logic [7:0] d);
        ent_t e;
        int   st;
        if (count_at(cyc) < Depth) begin
            // A new frame waits for the line to be free and for the FIFO latency
            st = (cyc + 2 > last_end) ? cyc + 2 : last_end;
            e.t = cyc;
            e.s = st;
            e.d = d;
            m.push_back(e);
            exp_bytes.push_back(d);
            last_end = st + Frame;
        end else if (!ov_set) begin
            ov_set = 1'b1;
            ov_at  = cyc + 1;
        end
    endtask

    task automatic model_clear();
        m.delete();
        exp_bytes.delete();
        ov_set   = 1'b0;
        last_end = 0;
    endtask

    // One clock: check the outputs for this cycle, then drive this cycle's input
    task automatic step(input logic wr, input logic [7:0] d);
        @(posedge clk);
        cyc++;
        #1;
        check_eq("tx", tx, tx_at(cyc));
        check_eq("busy", tx_busy, in_frame(cyc) || (count_at(cyc) != 0));
        check_eq("full", tx_full, count_at(cyc) == Depth);
        check_eq("ovf", tx_overflow, ov_set && (cyc >= ov_at));
        tx_data       = d;
        tx_data_fresh = wr;
        if (wr) model_write(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic check_rx();
        check_eq("rx_count", rx_q.size(), exp_bytes.size());
        for (int i = 0; i < rx_q.size() && i < exp_bytes.size(); i++) begin
            check_eq("rx_byte", rx_q[i], {1'b1, exp_bytes[i]});
        end
        rx_q.delete();
        exp_bytes.delete();
    endtask

    // Line decoder. It counts falling clock edges from the start-bit edge and
    // samples each bit one edge after the bit begins. The stop bit is kept as
    // bit 8 of each decoded entry.
    logic       rx_on;
    int         rx_cnt;
    logic [7:0] rx_sh;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_on  <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_on) begin
            if (tx == 1'b0) begin
                rx_on  <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt % Cpb == 1 && rx_cnt >= 5 && rx_cnt <= 33) rx_sh <= {tx, rx_sh[7:1]};
            if (rx_cnt == 37) begin
                rx_on <= 1'b0;
                rx_q.push_back({tx, rx_sh});
            end
        end
    end

    initial begin
        int         s;
        int         w;
        int         burst;
        logic       wr;
        logic [7:0] d;
        total         = 0;
        bad           = 0;
        cyc           = 0;
        tx_data       = 8'h00;
        tx_data_fresh = 1'b0;
        rst_n         = 1'b0;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", tx, 1'b1);
        check_eq("rst_busy", tx_busy, 1'b0);
        check_eq("rst_full", tx_full, 1'b0);
        check_eq("rst_ovf", tx_overflow, 1'b0);
        rst_n = 1'b1;

        // Test 1: a single 0xFF frame
        idle(3);
        step(1'b1, 8'hFF);
        idle(50);
        check_eq("t1_byte", (rx_q.size() > 0) ? rx_q[0] : 9'h0, 9'h1FF);
        check_rx();

        // Test 2: 0xA5
        step(1'b1, 8'hA5);
        idle(50);
        check_eq("t2_byte", (rx_q.size() > 0) ? rx_q[0] : 9'h0, 9'h1A5);
        check_rx();

        // Test 3: three writes on consecutive cycles
        step(1'b1, 8'h00);
        step(1'b1, 8'h55);
        step(1'b1, 8'h0F);
        idle(3 * Frame + 10);
        check_rx();

        // Test 6: write during the last stop-bit cycle of a frame, FIFO empty
        step(1'b1, $urandom_range(0, 255));
        s = m[m.size() - 1].s;
        while (cyc < s + Frame - 2) step(1'b0, 8'h00);
        step(1'b1, 8'hC3);
        check_eq("t6_cycle", cyc, s + Frame - 1);
        idle(Frame + 10);
        check_rx();

        // Test 4: six consecutive writes; the sixth is dropped
        for (int i = 0; i < 6; i++) step(1'b1, $urandom_range(0, 255));
        idle(5 * Frame + 10);
        check_eq("t4_frames", rx_q.size(), 5);
        check_eq("t4_ovf", tx_overflow, 1'b1);
        check_rx();

        // Test 5: asynchronous reset in the middle of a frame
        step(1'b1, 8'h3C);
        w = cyc;
        while (cyc < w + 2 + 15) step(1'b0, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t5_tx", tx, 1'b1);
        check_eq("t5_busy", tx_busy, 1'b0);
        check_eq("t5_ovf", tx_overflow, 1'b0);
        check_eq("t5_full", tx_full, 1'b0);
        model_clear();
        @(posedge clk);
        #4 rst_n = 1'b1;
        idle(Frame + 10);
        check_eq("t5_noframe", rx_q.size(), 0);
        check_rx();
        step(1'b1, 8'h96);
        idle(Frame + 10);
        check_rx();

        // Random traffic with occasional bursts that overfill the FIFO
        burst = 0;
        for (int i = 0; i < 400; i++) begin
            if (burst == 0 && $urandom_range(0, 60) == 0) burst = $urandom_range(2, 7);
            wr = (burst > 0) || ($urandom_range(0, 7) == 0);
            if (burst > 0) burst--;
            d = 8'($urandom_range(0, 255));
            step(wr, d);
        end
        idle(Depth * Frame + 2 * Frame);
        check_rx();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
